bcd_iter_ctrl: RTL and testbench

- Sequential binary-to-BCD converter controller. It shares one double-dabble shift/add-3 stage between two requesters and iterates that stage once per clock, instead of unrolling it combinationally.
- It arbitrates round-robin between channel 0 and channel 1, then sequences DATA_W iterations.
- It returns the packed BCD result with the winning channel id over a valid/ready handshake.
- It sits between the display/debug logic (requesters) and the seven-segment digit decoders (consumer).

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_iter_step.sv | 27 ++
 rtl/bcd_iter_ctrl.sv | 147 ++++++++++++++
 tb/tb_bcd_iter_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD controller.
// The digit-correction helper is shared by the iteration stage.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADD3_VAL    = 4'd3;

  // Pre-shift correction so that a digit >= 5 carries properly after doubling.
  function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
    if (digit >= BCD_ADD3_THRESH) begin
      bcd_add3 = digit + BCD_ADD3_VAL;
    end else begin
      bcd_add3 = digit;
    end
  endfunction

endpackage

// File: rtl/bcd_iter_step.sv
// One double-dabble iteration: parallel add-3 correction of every BCD digit,
// then a left shift by one of the whole {bcd, binary} working register.
module bcd_iter_step
  import bcd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS+DATA_W-1:0] work,
  output logic [4*DIGITS+DATA_W-1:0] next_work
);

  localparam int W = 4 * DIGITS + DATA_W;

  logic [W-1:0] corr_s;

  // Correct each BCD digit independently; the binary part passes through.
  always_comb begin
    corr_s = work;
    for (int d = 0; d < DIGITS; d++) begin
      corr_s[DATA_W + 4*d +: 4] = bcd_add3(work[DATA_W + 4*d +: 4]);
    end
  end

  assign next_work = corr_s << 1'b1;

endmodule

// File: rtl/bcd_iter_ctrl.sv
// Round-robin shared binary-to-BCD converter, one double-dabble iteration per clock.
// Optional completed-conversion counter: define BCD_ITER_CTRL_CNT_EN.
module bcd_iter_ctrl
  import bcd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3,
  parameter int CNT_W  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0_valid,
  input  logic [DATA_W-1:0]     i_req0_data,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [DATA_W-1:0]     i_req1_data,
  output logic                  o_req1_ready,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [4*DIGITS-1:0]   o_res_bcd,
  output logic                  o_res_id,
  output logic                  o_busy
`ifdef BCD_ITER_CTRL_CNT_EN
  ,
  output logic [15:0]           o_conv_cnt
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int W     = BCD_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  bcd_state_e         state_r;
  logic [W-1:0]       work_r;
  logic [W-1:0]       step_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               ptr_r;
  logic               id_r;
  logic               res_valid_r;
  logic [BCD_W-1:0]   res_bcd_r;
  logic               busy_r;
  logic               acc_s;
  logic               gnt_id_s;
  logic [DATA_W-1:0]  data_sel_s;

  // Grant is combinational: a lone valid wins, a tie goes to the pointer.
  always_comb begin
    acc_s    = 1'b0;
    gnt_id_s = 1'b0;
    if (state_r == IDLE) begin
      acc_s = i_req0_valid | i_req1_valid;
      if (i_req0_valid && i_req1_valid) begin
        gnt_id_s = ptr_r;
      end else if (i_req1_valid) begin
        gnt_id_s = 1'b1;
      end else begin
        gnt_id_s = 1'b0;
      end
    end else begin
      acc_s    = 1'b0;
      gnt_id_s = 1'b0;
    end
    data_sel_s = gnt_id_s ? i_req1_data : i_req0_data;
  end

  assign o_req0_ready = acc_s & ~gnt_id_s;
  assign o_req1_ready = acc_s & gnt_id_s;

  bcd_iter_step #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_step (
    .work      (work_r),
    .next_work (step_s)
  );

  // Control FSM, working register and registered result outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      work_r      <= {W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ptr_r       <= 1'b0;
      id_r        <= 1'b0;
      res_valid_r <= 1'b0;
      res_bcd_r   <= {BCD_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (acc_s) begin
            work_r  <= {{BCD_W{1'b0}}, data_sel_s};
            cnt_r   <= {CNT_W{1'b0}};
            id_r    <= gnt_id_s;
            ptr_r   <= ~gnt_id_s;
            state_r <= SHIFT;
            busy_r  <= 1'b1;
          end
        end
        SHIFT: begin
          work_r <= step_s;
          cnt_r  <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r     <= DONE;
            res_valid_r <= 1'b1;
            res_bcd_r   <= step_s[W-1 -: BCD_W];
          end
        end
        DONE: begin
          // No accept in the handshake cycle: IDLE is entered first.
          if (i_res_ready) begin
            state_r     <= IDLE;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign o_res_valid = res_valid_r;
  assign o_res_bcd   = res_bcd_r;
  assign o_res_id    = id_r;
  assign o_busy      = busy_r;

`ifdef BCD_ITER_CTRL_CNT_EN
  logic [15:0] conv_cnt_r;

  // Saturating count of result handshakes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      conv_cnt_r <= 16'd0;
    end else if (res_valid_r && i_res_ready && (conv_cnt_r != 16'hFFFF)) begin
      conv_cnt_r <= conv_cnt_r + 16'd1;
    end
  end

  assign o_conv_cnt = conv_cnt_r;
`endif

endmodule

// File: tb/tb_bcd_iter_ctrl.sv
// Directed bench for bcd_iter_ctrl: a vector table of single conversions
// plus hand-written sequences for arbitration, stall and mid-op reset.
module tb_bcd_iter_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req0_valid;
  logic [7:0]  i_req0_data;
  logic        o_req0_ready;
  logic        i_req1_valid;
  logic [7:0]  i_req1_data;
  logic        o_req1_ready;
  logic        o_res_valid;
  logic        i_res_ready;
  logic [11:0] o_res_bcd;
  logic        o_res_id;
  logic        o_busy;
`ifdef BCD_ITER_CTRL_CNT_EN
  logic [15:0] o_conv_cnt;
`endif

  bcd_iter_ctrl #(.DATA_W(8), .DIGITS(3), .CNT_W(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req0_valid (i_req0_valid),
    .i_req0_data  (i_req0_data),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_data  (i_req1_data),
    .o_req1_ready (o_req1_ready),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_res_bcd    (o_res_bcd),
    .o_res_id     (o_res_id),
    .o_busy       (o_busy)
`ifdef BCD_ITER_CTRL_CNT_EN
    ,
    .o_conv_cnt   (o_conv_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: accept and result-handshake events with their cycle numbers.
  int          cyc = 0;
  int          acc_cyc_q[$];
  logic        acc_id_q[$];
  logic [11:0] res_bcd_q[$];
  logic        res_id_q[$];

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_req0_ready && i_req0_valid) begin acc_cyc_q.push_back(cyc); acc_id_q.push_back(1'b0); end
    if (o_req1_ready && i_req1_valid) begin acc_cyc_q.push_back(cyc); acc_id_q.push_back(1'b1); end
    if (o_res_valid && i_res_ready) begin res_bcd_q.push_back(o_res_bcd); res_id_q.push_back(o_res_id); end
  end

  task automatic clear_q();
    acc_cyc_q.delete(); acc_id_q.delete(); res_bcd_q.delete(); res_id_q.delete();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_res_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    clear_q();
  endtask

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       exp_id;
    logic [11:0] exp_bcd;
  } vec_t;

  // One full conversion with a single valid requester, checked end to end.
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    i_req0_valid = v.v0; i_req0_data = v.d0;
    i_req1_valid = v.v1; i_req1_data = v.d1;
    #1;
    chk({tag, "_rdy0"}, 32'(o_req0_ready), 32'(!v.exp_id));
    chk({tag, "_rdy1"}, 32'(o_req1_ready), 32'(v.exp_id));
    @(posedge i_clk); #1;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    n = 1;
    while (!o_res_valid && n < 30) begin @(posedge i_clk); #1; n++; end
    chk({tag, "_latency"}, 32'(n), 32'd9);
    chk({tag, "_bcd"}, 32'(o_res_bcd), 32'(v.exp_bcd));
    chk({tag, "_id"}, 32'(o_res_id), 32'(v.exp_id));
    i_res_ready = 1'b1;
    @(posedge i_clk); #1;
    i_res_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(o_res_valid), 32'd0);
    chk({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  vec_t tbl[6];
  vec_t v42;
  int   nv;
  logic [11:0] hold_bcd;

  initial begin
    tbl[0] = '{v0:1'b1, d0:8'd255, v1:1'b0, d1:8'd0,   exp_id:1'b0, exp_bcd:12'h255};
    tbl[1] = '{v0:1'b0, d0:8'd0,   v1:1'b1, d1:8'd200, exp_id:1'b1, exp_bcd:12'h200};
    tbl[2] = '{v0:1'b1, d0:8'd9,   v1:1'b0, d1:8'd0,   exp_id:1'b0, exp_bcd:12'h009};
    tbl[3] = '{v0:1'b0, d0:8'd0,   v1:1'b1, d1:8'd128, exp_id:1'b1, exp_bcd:12'h128};
    tbl[4] = '{v0:1'b1, d0:8'd100, v1:1'b0, d1:8'd0,   exp_id:1'b0, exp_bcd:12'h100};
    tbl[5] = '{v0:1'b0, d0:8'd0,   v1:1'b1, d1:8'd59,  exp_id:1'b1, exp_bcd:12'h059};
    v42    = '{v0:1'b1, d0:8'd42,  v1:1'b0, d1:8'd0,   exp_id:1'b0, exp_bcd:12'h042};

    i_rst_n = 1'b0; i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    i_req0_data = 8'd0; i_req1_data = 8'd0; i_res_ready = 1'b0;
    repeat (3) @(posedge i_clk); #1;
    chk("rst_valid", 32'(o_res_valid), 32'd0);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_bcd",   32'(o_res_bcd), 32'd0);
    chk("rst_id",    32'(o_res_id), 32'd0);
    chk("rst_rdy0",  32'(o_req0_ready), 32'd0);
    chk("rst_rdy1",  32'(o_req1_ready), 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
`ifdef BCD_ITER_CTRL_CNT_EN
      if (i == 2) chk("conv_cnt_3", 32'(o_conv_cnt), 32'd3);
`endif
    end

    // Held valid on ch0: data 0 then 99, back-to-back at the minimum interval.
    clear_q();
    i_res_ready = 1'b1; i_req0_valid = 1'b1; i_req0_data = 8'd0;
    for (int k = 0; k < 20 && acc_cyc_q.size() < 1; k++) begin @(posedge i_clk); #1; end
    i_req0_data = 8'd99;
    for (int k = 0; k < 20 && acc_cyc_q.size() < 2; k++) begin @(posedge i_clk); #1; end
    i_req0_valid = 1'b0;
    for (int k = 0; k < 30 && res_bcd_q.size() < 2; k++) begin @(posedge i_clk); #1; end
    i_res_ready = 1'b0;
    chk("held_acc_count", 32'(acc_cyc_q.size()), 32'd2);
    chk("held_res_count", 32'(res_bcd_q.size()), 32'd2);
    if (res_bcd_q.size() >= 2 && acc_cyc_q.size() >= 2) begin
      chk("held_res0", 32'(res_bcd_q[0]), 32'h000);
      chk("held_res1", 32'(res_bcd_q[1]), 32'h099);
      chk("held_interval", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'd10);
    end

    // Both requesters held valid after reset: grants alternate from ch0.
    do_reset();
    i_res_ready = 1'b1;
    i_req0_valid = 1'b1; i_req0_data = 8'd123;
    i_req1_valid = 1'b1; i_req1_data = 8'd200;
    for (int k = 0; k < 60 && acc_cyc_q.size() < 5; k++) begin @(posedge i_clk); #1; end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    for (int k = 0; k < 30 && res_bcd_q.size() < 5; k++) begin @(posedge i_clk); #1; end
    i_res_ready = 1'b0;
    chk("rr_acc_count", 32'(acc_cyc_q.size()), 32'd5);
    chk("rr_res_count", 32'(res_bcd_q.size()), 32'd5);
    if (res_bcd_q.size() >= 5 && acc_id_q.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk($sformatf("rr_grant%0d", k), 32'(acc_id_q[k]), 32'(k % 2));
      chk("rr_res0_bcd", 32'(res_bcd_q[0]), 32'h123);
      chk("rr_res0_id",  32'(res_id_q[0]),  32'd0);
      chk("rr_res1_bcd", 32'(res_bcd_q[1]), 32'h200);
      chk("rr_res1_id",  32'(res_id_q[1]),  32'd1);
      chk("rr_res2_bcd", 32'(res_bcd_q[2]), 32'h123);
    end

    // Stall in DONE for 5 cycles with both requesters pushing.
    i_req0_valid = 1'b1; i_req0_data = 8'd37;
    @(posedge i_clk); #1;
    i_req0_valid = 1'b0;
    for (int k = 0; k < 30 && !o_res_valid; k++) begin @(posedge i_clk); #1; end
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    i_req0_data = 8'd1; i_req1_data = 8'd2;
    hold_bcd = 12'h037;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), 32'(o_res_valid), 32'd1);
      chk($sformatf("stall%0d_bcd", k),   32'(o_res_bcd), 32'(hold_bcd));
      chk($sformatf("stall%0d_id", k),    32'(o_res_id), 32'd0);
      chk($sformatf("stall%0d_rdy", k),   32'({o_req1_ready, o_req0_ready}), 32'd0);
      @(posedge i_clk); #1;
    end
    i_res_ready = 1'b1;
    @(posedge i_clk); #1;
    i_res_ready = 1'b0;
    chk("stall_release_idle", 32'(o_busy), 32'd0);
    chk("stall_release_grant", 32'({o_req1_ready, o_req0_ready}), 32'b10);
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;

    // Asynchronous reset during the 4th SHIFT cycle discards the conversion.
    i_req0_valid = 1'b1; i_req0_data = 8'd200;
    @(posedge i_clk); #1;
    i_req0_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #3;
    chk("midrst_busy_before", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_valid", 32'(o_res_valid), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    nv = 0;
    repeat (15) begin
      @(posedge i_clk); #1;
      if (o_res_valid) nv++;
    end
    chk("midrst_no_result", 32'(nv), 32'd0);
    run_vec(v42, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
